// File: rtl/nasti_lite_uart_ctrl.sv
// nasti_lite_uart_ctrl: bridges a byte TX/RX stream onto single-beat NASTI-lite
// accesses to one UART data register, with at most one bus transaction in flight.
module nasti_lite_uart_ctrl #(
  parameter int NASTI_ID_WIDTH = 8,
  parameter int NASTI_ADDR_WIDTH = 8,
  parameter int NASTI_DATA_WIDTH = 8,
  parameter logic [NASTI_ADDR_WIDTH-1:0] UART_ADDR = '0,
  parameter logic [NASTI_ID_WIDTH-1:0] CTRL_ID = '0
) (
  input  logic clk,
  input  logic rstn,
  input  logic [NASTI_DATA_WIDTH-1:0] tx_data,
  input  logic tx_valid,
  output logic tx_ready,
  output logic [NASTI_DATA_WIDTH-1:0] rx_data,
  output logic rx_valid,
  input  logic rx_ready,
  input  logic rx_en,
  output logic aw_valid,
  input  logic aw_ready,
  output logic [NASTI_ADDR_WIDTH-1:0] aw_addr,
  output logic [NASTI_ID_WIDTH-1:0] aw_id,
  output logic w_valid,
  input  logic w_ready,
  output logic [NASTI_DATA_WIDTH-1:0] w_data,
  input  logic b_valid,
  output logic b_ready,
  input  logic [1:0] b_resp,
  output logic ar_valid,
  input  logic ar_ready,
  output logic [NASTI_ADDR_WIDTH-1:0] ar_addr,
  output logic [NASTI_ID_WIDTH-1:0] ar_id,
  input  logic r_valid,
  output logic r_ready,
  input  logic [NASTI_DATA_WIDTH-1:0] r_data,
  input  logic [1:0] r_resp,
  output logic err,
  output logic busy
);
  localparam logic [2:0] IDLE = 3'd0, WRITE = 3'd1, WRESP = 3'd2, READ = 3'd3, RRESP = 3'd4;
  logic [2:0] state, state_nxt;
  logic tx_full, aw_done, w_done;
  logic [NASTI_DATA_WIDTH-1:0] tx_reg;
  logic [NASTI_DATA_WIDTH-1:0] fifo [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] count;
  logic aw_hs, w_hs, b_hs, tx_hs, push, pop;
  assign aw_addr = UART_ADDR;
  assign ar_addr = UART_ADDR;
  assign aw_id = CTRL_ID;
  assign ar_id = CTRL_ID;
  assign busy = state != IDLE;
  assign aw_valid = state == WRITE && !aw_done;
  assign w_valid = state == WRITE && !w_done;
  assign w_data = tx_reg;
  assign b_ready = state == WRESP;
  assign ar_valid = state == READ;
  assign r_ready = state == RRESP;
  assign tx_ready = rstn && !tx_full;
  assign rx_valid = count != 2'd0;
  assign rx_data = fifo[rd_ptr];
  assign aw_hs = aw_valid && aw_ready;
  assign w_hs = w_valid && w_ready;
  assign b_hs = b_valid && b_ready;
  assign tx_hs = tx_valid && tx_ready;
  assign push = r_valid && r_ready;
  assign pop = rx_valid && rx_ready;
  // A byte being handed over this cycle blocks a read start so TX keeps priority.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = tx_full ? WRITE : (!tx_valid && rx_en && count < 2'd2) ? READ : IDLE;
      WRITE:   state_nxt = ((aw_done || aw_hs) && (w_done || w_hs)) ? WRESP : WRITE;
      WRESP:   state_nxt = b_valid ? IDLE : WRESP;
      READ:    state_nxt = ar_ready ? RRESP : READ;
      RRESP:   state_nxt = r_valid ? IDLE : RRESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      tx_full <= 1'b0;
      tx_reg <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      tx_full <= b_hs ? 1'b0 : tx_hs ? 1'b1 : tx_full;
      if (tx_hs) tx_reg <= tx_data;
      aw_done <= state_nxt == WRITE && (aw_done || aw_hs);
      w_done <= state_nxt == WRITE && (w_done || w_hs);
      err <= err || (b_hs && b_resp != 2'd0) || (push && r_resp != 2'd0);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= r_data;
  end
endmodule

// File: doc/nasti_lite_uart_ctrl.md
NASTI_LITE_UART_CTRL -- requirements
Module: nasti_lite_uart_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NASTI_ID_WIDTH, 8, width of AW/AR ID.
- NASTI_ADDR_WIDTH, 8, address width.
- NASTI_DATA_WIDTH, 8, byte width of TX/RX data.
- UART_ADDR, 0, UART data register address.
- CTRL_ID, 0, constant ID driven on aw_id/ar_id.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk  in  1  single clock; everything is synchronous to its rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- tx_data  in  DATA  byte to transmit.
- tx_valid / tx_ready  in / out  1  TX byte handshake.
- rx_data  out  DATA  received byte, head of RX FIFO.
- rx_valid / rx_ready  out / in  1  RX byte handshake.
- rx_en  in  1  permits issuing UART reads.
- aw_valid / aw_ready  out / in  1  write-address handshake.
- aw_addr, ar_addr  out  ADDR  always UART_ADDR.
- aw_id, ar_id  out  ID  always CTRL_ID.
- w_valid / w_ready  out / in  1  write-data handshake.
- w_data  out  DATA  registered TX byte.
- b_valid / b_ready  in / out  1  write-response handshake.
- b_resp, r_resp  in  2  response codes.
- ar_valid / ar_ready  out / in  1  read-address handshake.
- r_valid / r_ready  in / out  1  read-data handshake.
- r_data  in  DATA  read byte.
- err  out  1  sticky; set on any non-zero b_resp/r_resp.
- busy  out  1  high whenever FSM is not IDLE.

Function
REQ-003 TX path SHALL be a 1-entry holding register: tx_ready = !tx_full; a tx handshake loads the register and sets tx_full.
REQ-004 RX path SHALL be a 2-entry FIFO: rx_valid = count != 0; rx_data = head entry; simultaneous push and pop SHALL leave the count unchanged.
REQ-005 FSM states SHALL be IDLE, WRITE, WRESP, READ, RRESP.
REQ-006 In IDLE, if tx_full, the FSM SHALL go to WRITE.
REQ-007 In IDLE, if !tx_full, rx_en is high, and the RX FIFO count is less than 2 (reservation for the response), the FSM SHALL go to READ; TX SHALL have priority over RX.
REQ-008 In WRITE, aw_valid and w_valid SHALL be asserted together with w_data = the TX register.
REQ-009 Each of aw_valid and w_valid SHALL drop independently after its own handshake.
REQ-010 The FSM SHALL go to WRESP once both the AW and W handshakes have completed, in the same cycle or in different cycles.
REQ-011 In WRESP, b_ready SHALL be 1; on b_valid, tx_full SHALL clear, err SHALL be set if b_resp != 0, and the FSM SHALL go to IDLE.
REQ-012 In READ, ar_valid SHALL be held until ar_ready, then the FSM SHALL go to RRESP.
REQ-013 ar_valid SHALL never be withdrawn before ar_ready, even if rx_en falls or a TX byte arrives; a blocked read therefore stalls TX, by design.
REQ-014 In RRESP, r_ready SHALL be 1; on r_valid, r_data SHALL be pushed into the FIFO, err SHALL be set if r_resp != 0, and the FSM SHALL go to IDLE.
REQ-015 A new TX byte SHALL be accepted while the FSM is in WRITE or WRESP only after tx_full clears; there SHALL be no overlapping transactions, at most 1 outstanding.
REQ-016 Minimum latency SHALL be: tx handshake -> aw_valid 2 cycles (IDLE decision registered); b_valid -> tx_ready high the next cycle.
REQ-017 All outputs to the bus SHALL be registered or decoded directly from state; there SHALL be no combinational path from any *_ready input to any *_valid output.

Reset
REQ-018 While rstn is low, the FSM SHALL be IDLE and tx_full, the FIFO count, err and all *_valid/*_ready outputs SHALL be 0; aw_addr/ar_addr/aw_id/ar_id SHALL hold their constants.
REQ-019 Reset mid-transaction SHALL abandon the transaction immediately; the bus slave is reset by the same rstn.

Verification
REQ-020 The bench SHALL cover: tx 0x41, aw_ready/w_ready high, b_valid after 1 cycle -> w_data 0x41, one AW and one W beat, tx_ready high again 1 cycle after b.
REQ-021 The bench SHALL cover: aw_ready 3 cycles before w_ready -> aw_valid drops after its beat, w_valid persists, exactly one WRESP.
REQ-022 The bench SHALL cover: rx_en=1, rx_ready=0, slave returns 0x11, 0x22, 0x33 -> FIFO holds 0x11, 0x22; no third AR until rx_ready pops.
REQ-023 The bench SHALL cover: tx_valid and rx_en rise in the same cycle in IDLE -> WRITE taken first, READ follows.
REQ-024 The bench SHALL cover: b_resp=2 -> err=1 and stays 1 until rstn low.
REQ-025 The bench SHALL cover: rstn low during RRESP -> all valids 0 the same cycle, FIFO empty, busy 0.
